// File: rtl/filter_seq_ctrl.sv
// Handshake-driven sequencer for the 33-tap transposed-form systolic FIR bank.
// Accepts one sample, starts the multipliers, waits (timeout-protected) for all busy flags, then shifts.
module filter_seq_ctrl #(
   parameter int NTAPS        = 33,
   parameter int TMO_W        = 6,
   parameter int MULT_TIMEOUT = 40
) (
   input  logic             clk30x,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sample_valid,
   output logic             sample_ready,
   input  logic [15:0]      xin,
   output logic [15:0]      x_hold,
   output logic             mult_start,
   input  logic [NTAPS-1:0] mult_busy,
   output logic             shift_en,
   output logic             yout_valid,
   output logic             err_timeout,
   input  logic             clr_err,
   output logic [15:0]      sample_cnt,
   output logic [7:0]       drop_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      ARM,
      WAIT,
      SHIFT,
      DONE
   } state_t;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MULT_TIMEOUT - 1);

   state_t           state;
   logic [TMO_W-1:0] tmo_cnt;
   logic             all_idle;

   assign all_idle     = (mult_busy == '0);
   assign sample_ready = en && (state == IDLE);

   // Strobes are set on the edge that enters their state, so each is a registered state decode.
   always_ff @(posedge clk30x or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         tmo_cnt     <= '0;
         x_hold      <= '0;
         mult_start  <= 1'b0;
         shift_en    <= 1'b0;
         yout_valid  <= 1'b0;
         err_timeout <= 1'b0;
         sample_cnt  <= '0;
         drop_cnt    <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so later writes in this block (a timeout
         // setting err_timeout) cleanly override earlier defaults (clr_err) on the same edge.
         mult_start <= 1'b0;
         shift_en   <= 1'b0;
         yout_valid <= 1'b0;
         if (clr_err) begin
            err_timeout <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (sample_valid && en) begin
                  x_hold     <= xin;
                  mult_start <= 1'b1;
                  state      <= START;
               end
            end
            START: begin
               tmo_cnt <= '0;
               state   <= ARM;
            end
            ARM: begin
               state <= WAIT;
            end
            WAIT: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               // All-idle is tested first so it wins over a timeout on the same cycle.
               if (all_idle) begin
                  shift_en   <= 1'b1;
                  sample_cnt <= sample_cnt + 16'd1;
                  state      <= SHIFT;
               end else if (tmo_cnt == TMO_LAST) begin
                  err_timeout <= 1'b1;
                  if (drop_cnt != 8'hFF) begin
                     drop_cnt <= drop_cnt + 8'd1;
                  end
                  state <= IDLE;
               end
            end
            SHIFT: begin
               yout_valid <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Scoreboard bench for filter_seq_ctrl: a driver pushes predicted outcomes, a monitor pops on strobes.
module tb_filter_seq_ctrl;

   localparam int NTAPS        = 33;
   localparam int TMO_W        = 6;
   localparam int MULT_TIMEOUT = 40;

   logic             clk30x;
   logic             rst_n;
   logic             en;
   logic             sample_valid;
   logic             sample_ready;
   logic [15:0]      xin;
   logic [15:0]      x_hold;
   logic             mult_start;
   logic [NTAPS-1:0] mult_busy;
   logic             shift_en;
   logic             yout_valid;
   logic             err_timeout;
   logic             clr_err;
   logic [15:0]      sample_cnt;
   logic [7:0]       drop_cnt;

   filter_seq_ctrl #(
      .NTAPS        (NTAPS),
      .TMO_W        (TMO_W),
      .MULT_TIMEOUT (MULT_TIMEOUT)
   ) dut (
      .clk30x       (clk30x),
      .rst_n        (rst_n),
      .en           (en),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .xin          (xin),
      .x_hold       (x_hold),
      .mult_start   (mult_start),
      .mult_busy    (mult_busy),
      .shift_en     (shift_en),
      .yout_valid   (yout_valid),
      .err_timeout  (err_timeout),
      .clr_err      (clr_err),
      .sample_cnt   (sample_cnt),
      .drop_cnt     (drop_cnt)
   );

   // One predicted outcome per accepted sample; k = first WAIT cycle offset with all lanes idle.
   typedef struct {
      int          hs;
      int          k;
      bit          tmo;
      logic [15:0] x;
      logic [15:0] scnt;
      logic [7:0]  dcnt;
   } exp_t;

   exp_t             exp_q[$];
   int               total = 0;
   int               bad = 0;
   int               cyc = 0;
   int               win_lo;
   int               win_hi;
   int               last_hs;
   int               n_start = 0;
   int               n_issued = 0;
   logic [NTAPS-1:0] fixed_mask;
   logic [NTAPS-1:0] last_mask;
   logic [15:0]      m_scnt;
   logic [7:0]       m_dcnt;

   initial clk30x = 1'b0;
   always #5 clk30x = ~clk30x;

   always @(posedge clk30x) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic logic [NTAPS-1:0] rand_mask();
      logic [63:0]      v;
      logic [NTAPS-1:0] m;
      v = {$urandom, $urandom};
      m = v[NTAPS-1:0];
      if (m == '0) m = {{(NTAPS-1){1'b0}}, 1'b1};
      return m;
   endfunction

   // Multiplier model: some lane busy for every cycle in [win_lo, win_hi], all idle otherwise.
   initial begin
      mult_busy = '0;
      forever begin
         @(negedge clk30x);
         if (cyc >= win_lo && cyc <= win_hi) begin
            if (cyc == win_hi && last_mask != '0) mult_busy = last_mask;
            else if (fixed_mask != '0)            mult_busy = fixed_mask;
            else                                  mult_busy = rand_mask();
         end else begin
            mult_busy = '0;
         end
      end
   end

   // Monitor: pops the oldest prediction whenever the DUT reports a finished or dropped sample.
   initial begin
      exp_t e;
      bit   prev_shift;
      bit   prev_err;
      prev_shift = 1'b0;
      prev_err   = 1'b0;
      forever begin
         @(negedge clk30x);
         if (!rst_n) begin
            prev_shift = 1'b0;
            prev_err   = 1'b0;
         end else begin
            if (mult_start) begin
               n_start++;
               check("start_pending", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  check("start_cycle", cyc, exp_q[$].hs + 1);
                  check("start_xhold", x_hold, exp_q[$].x);
               end
            end
            if (shift_en) begin
               check("shift_pending", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  check("shift_not_timeout", !exp_q[0].tmo, 1);
                  check("shift_cycle", cyc, exp_q[0].hs + 4 + exp_q[0].k);
               end
            end
            if (yout_valid) begin
               check("yout_pending", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("yout_not_timeout", !e.tmo, 1);
                  check("yout_cycle", cyc, e.hs + 5 + e.k);
                  check("yout_after_shift", prev_shift, 1);
                  check("yout_xhold", x_hold, e.x);
                  check("yout_sample_cnt", sample_cnt, e.scnt);
               end
            end
            if (err_timeout && !prev_err) begin
               check("tmo_pending", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("tmo_expected", e.tmo, 1);
                  check("tmo_cycle", cyc, e.hs + 3 + MULT_TIMEOUT);
                  check("tmo_drop_cnt", drop_cnt, e.dcnt);
                  check("tmo_ready_idle", sample_ready, en);
               end
            end
            prev_shift = shift_en;
            prev_err   = err_timeout;
         end
      end
   end

   // Issue one sample. Busy (some lane) is high from cycle 1 to r-1 after the handshake.
   task automatic send(input logic [15:0] x, input int r, input logic [NTAPS-1:0] fmask,
                       input logic [NTAPS-1:0] lmask, input int drop_en_at, input int clr_at,
                       input int rst_at, output bit was_tmo);
      exp_t e;
      int   waited;
      int   done_rel;
      #1;
      waited = 0;
      while (!sample_ready) begin
         @(negedge clk30x);
         #1;
         waited++;
         if (waited > 200) begin
            $display("FAIL ready_wait: sample_ready never rose within 200 cycles (cycle %0d)", cyc);
            $fatal(1, "ready wait expired");
         end
      end
      e.hs  = cyc;
      e.k   = (r > 3) ? r - 3 : 0;
      e.tmo = (e.k >= MULT_TIMEOUT);
      e.x   = x;
      if (e.tmo) m_dcnt = (m_dcnt == 8'hFF) ? 8'hFF : m_dcnt + 8'd1;
      else       m_scnt = m_scnt + 16'd1;
      e.scnt = m_scnt;
      e.dcnt = m_dcnt;
      exp_q.push_back(e);
      n_issued++;
      last_hs      = cyc;
      sample_valid = 1'b1;
      xin          = x;
      fixed_mask   = fmask;
      last_mask    = lmask;
      win_lo       = cyc + 1;
      win_hi       = cyc + r - 1;
      done_rel     = e.tmo ? 3 + MULT_TIMEOUT : 6 + e.k;
      for (int rel = 1; rel <= done_rel; rel++) begin
         @(negedge clk30x);
         if (rel == 1) sample_valid = 1'b0;
         clr_err = (rel == clr_at);
         if (rel == drop_en_at) en = 1'b0;
         if (rel == rst_at) begin
            #1 rst_n = 1'b0;
            #1;
            check("arst_mult_start", mult_start, 0);
            check("arst_shift_en", shift_en, 0);
            check("arst_yout_valid", yout_valid, 0);
            check("arst_err", err_timeout, 0);
            check("arst_x_hold", x_hold, 0);
            check("arst_sample_cnt", sample_cnt, 0);
            check("arst_drop_cnt", drop_cnt, 0);
            check("arst_ready", sample_ready, en);
            exp_q.delete();
            m_scnt = '0;
            m_dcnt = '0;
            win_lo = 1;
            win_hi = 0;
            repeat (3) @(negedge clk30x);
            rst_n   = 1'b1;
            was_tmo = 1'b0;
            return;
         end
      end
      if (!e.tmo) check("ready_back", sample_ready, en);
      was_tmo = e.tmo;
   endtask

   task automatic clear_err();
      clr_err = 1'b1;
      @(negedge clk30x);
      clr_err = 1'b0;
      check("err_cleared", err_timeout, 0);
   endtask

   initial begin
      bit               t;
      int               hs0;
      int               r;
      logic [NTAPS-1:0] ones;
      logic [NTAPS-1:0] bit7;
      logic [NTAPS-1:0] bit32;
      ones         = '1;
      bit7         = '0;
      bit7[7]      = 1'b1;
      bit32        = '0;
      bit32[32]    = 1'b1;
      rst_n        = 1'b0;
      en           = 1'b0;
      sample_valid = 1'b0;
      clr_err      = 1'b0;
      xin          = '0;
      fixed_mask   = '0;
      last_mask    = '0;
      win_lo       = 1;
      win_hi       = 0;
      m_scnt       = '0;
      m_dcnt       = '0;

      repeat (2) @(negedge clk30x);
      check("rst_ready_en0", sample_ready, 0);
      check("rst_mult_start", mult_start, 0);
      check("rst_shift_en", shift_en, 0);
      check("rst_yout_valid", yout_valid, 0);
      check("rst_err", err_timeout, 0);
      check("rst_x_hold", x_hold, 0);
      check("rst_sample_cnt", sample_cnt, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      en = 1'b1;
      #1 check("rst_ready_en1", sample_ready, 1);
      @(negedge clk30x);
      rst_n = 1'b1;

      // Minimum-period samples, back to back.
      send(16'h1234, 0, '0, '0, 0, 0, 0, t);
      hs0 = last_hs;
      send(16'h4321, 4, '0, '0, 0, 0, 0, t);
      check("b2b_period", last_hs - hs0, 6);

      // 16-cycle multiplier, then one extra busy cycle on lane 32 alone.
      send(16'h0F0F, 18, ones, '0, 0, 0, 0, t);
      send(16'hF0F0, 19, ones, bit32, 0, 0, 0, t);
      // Release on the very last allowed WAIT cycle: idle beats timeout.
      send(16'h5A5A, 3 + MULT_TIMEOUT - 1, '0, '0, 0, 0, 0, t);

      // Hung lane 7, clear, then clr_err colliding with the timeout edge.
      send(16'h0007, 1000, bit7, '0, 0, 0, 0, t);
      clear_err();
      send(16'h0008, 1000, bit7, '0, 0, 2 + MULT_TIMEOUT, 0, t);
      check("clr_vs_set", err_timeout, 1);
      clear_err();

      // en dropped during WAIT: sample finishes, then nothing is accepted until en returns.
      send(16'hCAFE, 20, '0, '0, 5, 0, 0, t);
      sample_valid = 1'b1;
      xin          = 16'hBEEF;
      repeat (4) begin
         @(negedge clk30x);
         check("hold_off_ready", sample_ready, 0);
      end
      en = 1'b1;
      send(16'hBEEF, 7, '0, '0, 0, 0, 0, t);

      for (int i = 0; i < 40; i++) begin
         r = ($urandom_range(0, 7) == 0) ? $urandom_range(MULT_TIMEOUT - 2, MULT_TIMEOUT + 6)
                                         : $urandom_range(0, 25);
         send(16'($urandom), r, '0, '0, 0, 0, 0, t);
         if (t) clear_err();
      end

      // Asynchronous reset in the middle of WAIT.
      send(16'hA5C3, 1000, '0, '0, 0, 0, 10, t);
      repeat (6) @(negedge clk30x);
      check("post_arst_sample_cnt", sample_cnt, 0);

      // Saturating drop counter.
      for (int i = 0; i < 300; i++) begin
         send(16'(i), 1000, bit7, '0, 0, 0, 0, t);
         clear_err();
      end
      check("drop_saturated", drop_cnt, 8'hFF);
      send(16'h2468, 6, '0, '0, 0, 0, 0, t);

      repeat (4) @(negedge clk30x);
      check("queue_drained", exp_q.size(), 0);
      check("start_count", n_start, n_issued);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
